sort_arbiter: RTL and testbench

SORT_ARBITER -- requirements
Module: sort_arbiter

---
 rtl/sort_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_sort_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_arbiter.sv
// -----------------------------------------------------------------------------
// sort_arbiter
//
// Shares one sorter between two requesters. A job word is taken from the
// granted requester (round-robin), launched to the sorter, and the sorter's
// completion (a rising edge of sort_done) or a timeout produces one delivered
// result tagged with the owning requester index.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req0/req1, data0/data1    requester job request (level) and job word
//   ack0/ack1                 one-cycle pulse: job word captured
//   sort_start, sort_data     launch pulse and job word towards the sorter
//   sort_result, sort_done    sorter result word and completion level
//   result, result_valid      delivered result word and its one-cycle qualifier
//   result_id, result_err     owning requester index, timeout flag
//   busy                      high whenever the FSM is not idle
//   jobs_done                 count of error-free deliveries (wraps)
// -----------------------------------------------------------------------------
module sort_arbiter #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 64,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic [DW-1:0] data0,
    input  logic [DW-1:0] data1,
    output logic          ack0,
    output logic          ack1,
    output logic          sort_start,
    output logic [DW-1:0] sort_data,
    input  logic [DW-1:0] sort_result,
    input  logic          sort_done,
    output logic [DW-1:0] result,
    output logic          result_valid,
    output logic          result_id,
    output logic          result_err,
    output logic          busy,
    output logic [CW-1:0] jobs_done
);

    // Counter holds 0 .. TIMEOUT-1.
    localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } state_t;

    state_t          state_q;
    logic            last_q;       // index granted most recently
    logic            id_q;         // index owning the job in flight
    logic [CNTW-1:0] cnt_q;
    logic            done_q;       // previous-cycle copy of sort_done
    logic            ack0_q;
    logic            ack1_q;
    logic            start_q;
    logic [DW-1:0]   sort_data_q;
    logic [DW-1:0]   result_q;
    logic            valid_q;
    logic            rid_q;
    logic            err_q;
    logic            busy_q;
    logic [CW-1:0]   jobs_q;

    logic            grant_id_d;
    logic            done_rise_s;

    // Round-robin pick: a lone request wins; on contention the requester not
    // granted last wins.
    always_comb begin
        grant_id_d = 1'b0;
        if (req0 && req1) begin
            grant_id_d = ~last_q;
        end else if (req1) begin
            grant_id_d = 1'b1;
        end else begin
            grant_id_d = 1'b0;
        end
    end

    // A done level left over from an earlier job has no rising edge, so it
    // cannot complete the current one.
    assign done_rise_s = sort_done & ~done_q;

    // Job FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;      // req0 wins the first contention
            id_q        <= 1'b0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            start_q     <= 1'b0;
            sort_data_q <= '0;
            result_q    <= '0;
            valid_q     <= 1'b0;
            rid_q       <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            jobs_q      <= '0;
        end else begin
            done_q <= sort_done;
            case (state_q)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        state_q     <= ST_LAUNCH;
                        id_q        <= grant_id_d;
                        last_q      <= grant_id_d;
                        sort_data_q <= grant_id_d ? data1 : data0;
                        ack0_q      <= ~grant_id_d;
                        ack1_q      <= grant_id_d;
                        start_q     <= 1'b1;
                        busy_q      <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_LAUNCH: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    start_q <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Completion is checked first so it wins a tie with the timeout.
                    if (done_rise_s) begin
                        result_q <= sort_result;
                        err_q    <= 1'b0;
                        valid_q  <= 1'b1;
                        rid_q    <= id_q;
                        jobs_q   <= jobs_q + CW'(1);
                        state_q  <= ST_DELIVER;
                    end else if (cnt_q == CNT_LAST) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                        valid_q  <= 1'b1;
                        rid_q    <= id_q;
                        state_q  <= ST_DELIVER;
                    end else begin
                        cnt_q <= cnt_q + CNTW'(1);
                    end
                end
                ST_DELIVER: begin
                    valid_q <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    start_q <= 1'b0;
                    valid_q <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack0         = ack0_q;
    assign ack1         = ack1_q;
    assign sort_start   = start_q;
    assign sort_data    = sort_data_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign result_id    = rid_q;
    assign result_err   = err_q;
    assign busy         = busy_q;
    assign jobs_done    = jobs_q;

endmodule

// File: tb/tb_sort_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sort_arbiter: directed and randomized jobs against a job-level reference
// model (round-robin grant rule, byte-sorting sorter, cycle budget per job).
// -----------------------------------------------------------------------------
module tb_sort_arbiter;

    localparam int DW = 32;
    localparam int TO = 8;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          req0, req1;
    logic [DW-1:0] data0, data1;
    logic          ack0, ack1;
    logic          sort_start;
    logic [DW-1:0] sort_data;
    logic [DW-1:0] sort_result;
    logic          sort_done;
    logic [DW-1:0] result;
    logic          result_valid;
    logic          result_id;
    logic          result_err;
    logic          busy;
    logic [CW-1:0] jobs_done;

    // sorter model controls
    int            srt_lat;
    int            cd;
    logic          pend;
    logic          auto_done;
    logic [DW-1:0] auto_res;
    logic          man_en;
    logic          man_done;
    logic [DW-1:0] man_res;

    // reference model state
    int vectors;
    int misc;
    int m_last;
    int m_jobs;
    int fair_ids[6];

    sort_arbiter #(.DW(DW), .TIMEOUT(TO), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .data0(data0), .data1(data1),
        .ack0(ack0), .ack1(ack1),
        .sort_start(sort_start), .sort_data(sort_data),
        .sort_result(sort_result), .sort_done(sort_done),
        .result(result), .result_valid(result_valid), .result_id(result_id),
        .result_err(result_err), .busy(busy), .jobs_done(jobs_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sort_done   = man_en ? man_done : auto_done;
    assign sort_result = man_en ? man_res : auto_res;

    // Sorter: bytes in descending order
    function automatic logic [31:0] sortb(input logic [31:0] w);
        logic [7:0] b[4];
        logic [7:0] t;
        for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3 - i; j++)
                if (b[j] < b[j+1]) begin
                    t = b[j]; b[j] = b[j+1]; b[j+1] = t;
                end
        return {b[0], b[1], b[2], b[3]};
    endfunction

    // Sorter model: drops done on start, raises it srt_lat edges later (never if < 0).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            auto_done <= 1'b0; pend <= 1'b0; cd <= 0; auto_res <= '0;
        end else if (sort_start) begin
            auto_res <= sortb(sort_data);
            if (srt_lat == 0) begin
                auto_done <= 1'b1; pend <= 1'b0;
            end else if (srt_lat < 0) begin
                auto_done <= 1'b0; pend <= 1'b0;
            end else begin
                auto_done <= 1'b0; pend <= 1'b1; cd <= srt_lat;
            end
        end else if (pend) begin
            if (cd == 1) begin
                auto_done <= 1'b1; pend <= 1'b0;
            end else begin
                cd <= cd - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            misc++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ctl"}, 64'({ack0, ack1, sort_start, result_valid, result_err, result_id, busy}), 64'd0);
        chk({tag, "_sort_data"}, 64'(sort_data), 64'd0);
        chk({tag, "_result"}, 64'(result), 64'd0);
        chk({tag, "_jobs_done"}, 64'(jobs_done), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        check_reset("rst");
        rst = 1'b0;
        m_last = 1;
        m_jobs = 0;
    endtask

    // Runs one job; entered and left at a negedge in an idle cycle.
    task automatic do_job(input bit r0, input bit r1, input bit hold, input int lat,
                          input bit use_man, input int drop, input int rise,
                          input logic [31:0] d0, input logic [31:0] d1);
        int g;
        int det;
        int expc;
        int k;
        bit ok;
        bit seen;
        logic [31:0] expd;
        logic [31:0] expr;
        srt_lat = lat;
        data0 = d0; data1 = d1;
        req0 = r0;  req1 = r1;
        if (r0 && r1) g = (m_last == 0) ? 1 : 0;
        else          g = r1 ? 1 : 0;
        m_last = g;
        expd = (g == 1) ? d1 : d0;
        det  = use_man ? rise - 2 : lat;
        ok   = (det >= 0) && (det <= TO - 1);
        expc = ok ? det + 2 : TO + 1;
        expr = ok ? (use_man ? man_res : sortb(expd)) : 32'd0;
        @(negedge clk);
        chk("grant_ack", 64'({ack1, ack0}), (g == 1) ? 64'd2 : 64'd1);
        chk("launch_start_busy", 64'({sort_start, busy}), 64'd3);
        chk("launch_data", 64'(sort_data), 64'(expd));
        if (!hold) begin
            if (g == 1) req1 = 1'b0;
            else        req0 = 1'b0;
        end
        k = 0; seen = 0;
        for (int i = 1; i <= TO + 4 && !seen; i++) begin
            if (use_man) man_done = (i < drop) || (i >= rise);
            @(negedge clk);
            if (i == 1) chk("pulse_end", 64'({ack0, ack1, sort_start}), 64'd0);
            if (result_valid) begin
                seen = 1; k = i;
            end
        end
        chk("latency", 64'(k), 64'(expc));
        if (ok) m_jobs = (m_jobs + 1) % (1 << CW);
        chk("result", 64'(result), 64'(expr));
        chk("result_id", 64'(result_id), 64'(g));
        chk("result_err", 64'(result_err), 64'(!ok));
        chk("jobs_done", 64'(jobs_done), 64'(m_jobs));
        @(negedge clk);
        chk("deliver_end", 64'({result_valid, busy}), 64'd0);
    endtask

    initial begin
        int jobs_before;
        logic [1:0] r;
        vectors = 0; misc = 0;
        m_last = 1; m_jobs = 0;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
        srt_lat = 1; man_en = 1'b0; man_done = 1'b0; man_res = '0;
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset("post_reset");

        // minimum latency: done raised right at the launch edge
        do_job(1, 0, 0, 0, 0, 0, 0, 32'hA1B2C3D4, 32'h0);
        chk("minlat_result", 64'(result), 64'h00000000D4C3B2A1);
        do_reset();

        // single job with a 6-cycle sorter
        do_job(1, 0, 0, 6, 0, 0, 0, 32'h12347856, 32'h0);
        chk("single_result", 64'(result), 64'h0000000078563412);
        chk("single_jobs", 64'(jobs_done), 64'd1);
        do_reset();

        // contention from reset: req0 first, then the still-pending req1
        do_job(1, 1, 0, 2, 0, 0, 0, 32'h01020304, 32'h0A0B0C0D);
        do_job(0, 1, 0, 3, 0, 0, 0, 32'h01020304, 32'h0A0B0C0D);

        // fairness: both held for 6 jobs
        for (int i = 0; i < 6; i++) begin
            do_job(1, 1, 1, 1 + i, 0, 0, 0, 32'h11223344 + i, 32'h55667788 + i);
            fair_ids[i] = int'(result_id);
        end
        for (int i = 0; i < 6; i++) chk("fair_order", 64'(fair_ids[i]), 64'(i % 2));

        // timeout boundaries: tie goes to completion, later or absent done times out
        jobs_before = m_jobs;
        do_job(1, 0, 0, TO - 1, 0, 0, 0, 32'hDEADBEEF, 32'h0);
        do_job(0, 1, 0, TO, 0, 0, 0, 32'h0, 32'hFEEDFACE);
        do_job(1, 0, 0, -1, 0, 0, 0, 32'h13579BDF, 32'h0);
        chk("timeout_jobs", 64'(jobs_done), 64'((jobs_before + 1) % (1 << CW)));

        // stale done held across launch, dropped, raised 3 cycles later
        man_en = 1'b1; man_res = 32'hCAFEF00D; man_done = 1'b1;
        @(negedge clk);
        chk("stale_idle", 64'({busy, result_valid}), 64'd0);
        do_job(1, 0, 0, 0, 1, 3, 6, 32'h0F0F0F0F, 32'h0);

        // reset two cycles into WAIT
        man_done = 1'b0; req0 = 1'b1; data0 = 32'h89ABCDEF;
        @(negedge clk);
        chk("mid_ack", 64'({ack1, ack0}), 64'd1);
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check_reset("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        m_last = 1; m_jobs = 0;
        man_done = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("after_rst_quiet", 64'({result_valid, busy, result_err}), 64'd0);
        end
        man_en = 1'b0; man_done = 1'b0;

        // randomized jobs
        for (int n = 0; n < 40; n++) begin
            r = 2'($urandom_range(1, 3));
            do_job(r[0], r[1], ($urandom_range(0, 3) == 0), int'($urandom_range(1, TO + 1)),
                   0, 0, 0, 32'($urandom), 32'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule
